// File: rtl/bank_cycle_sequencer.sv
// 6509 bank selector: holds the execution/indirect bank registers and picks the bank driven on
// each bus cycle, applying the indirect bank on (zp),Y effective-address cycles. Option: CMOS_RDY_EN.
module bank_cycle_sequencer #(
  parameter int unsigned               BANK_WIDTH = 4,
  parameter logic [BANK_WIDTH-1:0]     RESET_BANK = 4'hF
) (
  input  logic                  clock,
  input  logic                  _reset,
  input  logic                  r_w,
  input  logic                  rdy,
  input  logic                  sync,
  input  logic [15:0]           address_cpu,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic [BANK_WIDTH-1:0] address_bank,
  output logic                  sel_indirect,
  output logic [BANK_WIDTH-1:0] exec_bank,
  output logic [BANK_WIDTH-1:0] ind_bank
);

  typedef enum logic [2:0] {
    StIdle,
    StOpr,
    StPtrL,
    StPtrH,
    StEa1,
    StEa2
  } state_e;

  localparam logic [7:0] OpLdaIndY = 8'hB1;
  localparam logic [7:0] OpStaIndY = 8'h91;

  state_e                state_q, state_d;
  logic [BANK_WIDTH-1:0] exec_bank_q, exec_bank_d;
  logic [BANK_WIDTH-1:0] ind_bank_q, ind_bank_d;

  logic ce;
  logic adv;
  logic opc_hit;

  assign ce      = (address_cpu[15:1] == 15'd0);
  assign opc_hit = (data_in == OpLdaIndY) || (data_in == OpStaIndY);

`ifdef CMOS_RDY_EN
  // 65C02: RDY stalls every cycle, writes included.
  assign adv = rdy;
`else
  // NMOS: RDY is ignored on write cycles.
  assign adv = rdy | ~r_w;
`endif

  always_comb begin
    exec_bank_d = exec_bank_q;
    ind_bank_d  = ind_bank_q;
    // Register writes are deliberately not gated by rdy.
    if (ce && !r_w) begin
      if (address_cpu[0]) begin
        ind_bank_d = data_in[BANK_WIDTH-1:0];
      end else begin
        exec_bank_d = data_in[BANK_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        StIdle:  if (sync && opc_hit) state_d = StOpr;
        StOpr:   state_d = StPtrL;
        StPtrL:  state_d = StPtrH;
        StPtrH:  state_d = StEa1;
        StEa1:   state_d = StEa2;
        // A sync here is the next opcode fetch (LDA without page cross); decode it now.
        StEa2:   state_d = (sync && opc_hit) ? StOpr : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= StIdle;
      exec_bank_q <= RESET_BANK;
      ind_bank_q  <= RESET_BANK;
    end else begin
      state_q     <= state_d;
      exec_bank_q <= exec_bank_d;
      ind_bank_q  <= ind_bank_d;
    end
  end

  always_comb begin
    sel_indirect = (state_q == StEa1) || ((state_q == StEa2) && !sync);
    data_oe      = ce & r_w;
    data_out     = 8'h00;
    if (data_oe) begin
      data_out = {{(8 - BANK_WIDTH){1'b0}}, (address_cpu[0] ? ind_bank_q : exec_bank_q)};
    end
    // Bank registers must be readable whatever bank the CPU is running from.
    if (ce && r_w) begin
      address_bank = RESET_BANK;
    end else if (sel_indirect) begin
      address_bank = ind_bank_q;
    end else begin
      address_bank = exec_bank_q;
    end
  end

  assign exec_bank = exec_bank_q;
  assign ind_bank  = ind_bank_q;

endmodule

// File: tb/tb_bank_cycle_sequencer.sv
// Directed bench for bank_cycle_sequencer: each bus cycle queues its hand-derived outputs and
// a negedge monitor pops and compares them. Honours CMOS_RDY_EN for the RDY-on-write case.
module tb_bank_cycle_sequencer;

  logic        clock;
  logic        _reset;
  logic        r_w;
  logic        rdy;
  logic        sync;
  logic [15:0] address_cpu;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [3:0]  address_bank;
  logic        sel_indirect;
  logic [3:0]  exec_bank;
  logic [3:0]  ind_bank;

  bank_cycle_sequencer dut (
    .clock        (clock),
    ._reset       (_reset),
    .r_w          (r_w),
    .rdy          (rdy),
    .sync         (sync),
    .address_cpu  (address_cpu),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .address_bank (address_bank),
    .sel_indirect (sel_indirect),
    .exec_bank    (exec_bank),
    .ind_bank     (ind_bank)
  );

  typedef struct {
    int         id;
    logic       sel;
    logic [3:0] ab;
    logic       oe;
    logic [7:0] dout;
    logic [3:0] ex;
    logic [3:0] in;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;
  logic [3:0] ex_e = 4'hF;
  logic [3:0] in_e = 4'hF;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, id, act, req);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel_indirect", e.id, {7'd0, sel_indirect}, {7'd0, e.sel});
      chk("address_bank", e.id, {4'd0, address_bank}, {4'd0, e.ab});
      chk("data_oe",      e.id, {7'd0, data_oe},      {7'd0, e.oe});
      chk("data_out",     e.id, data_out,             e.dout);
      chk("exec_bank",    e.id, {4'd0, exec_bank},    {4'd0, e.ex});
      chk("ind_bank",     e.id, {4'd0, ind_bank},     {4'd0, e.in});
    end
  end

  // One bus cycle: apply inputs just after the edge and queue what the outputs must be.
  task automatic bus(input logic rst, input logic rw, input logic rd, input logic sy,
                     input logic [15:0] a, input logic [7:0] d,
                     input logic es, input logic [3:0] eab, input logic eoe,
                     input logic [7:0] edo);
    exp_t e;
    @(posedge clock);
    #1;
    _reset      = rst;
    r_w         = rw;
    rdy         = rd;
    sync        = sy;
    address_cpu = a;
    data_in     = d;
    e.id = vec_id; e.sel = es; e.ab = eab; e.oe = eoe; e.dout = edo; e.ex = ex_e; e.in = in_e;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    _reset = 1'b0; r_w = 1'b1; rdy = 1'b1; sync = 1'b0;
    address_cpu = 16'h1000; data_in = 8'h00;

    // Reset and register access
    bus(0, 1, 1, 0, 16'h1000, 8'h00, 0, 4'hF, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h1000, 8'h00, 0, 4'hF, 0, 8'h00);
    bus(1, 0, 1, 0, 16'h0000, 8'h03, 0, 4'hF, 0, 8'h00); ex_e = 4'h3;
    bus(1, 0, 1, 0, 16'h0001, 8'h07, 0, 4'h3, 0, 8'h00); in_e = 4'h7;
    bus(1, 1, 1, 0, 16'h0001, 8'h00, 0, 4'hF, 1, 8'h07);
    bus(1, 1, 1, 0, 16'h0000, 8'h00, 0, 4'hF, 1, 8'h03);

    // STA (zp),Y
    bus(1, 1, 1, 1, 16'h2000, 8'h91, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2001, 8'h10, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0010, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0011, 8'h40, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h4000, 8'h00, 1, 4'h7, 0, 8'h00);
    bus(1, 0, 1, 0, 16'h4010, 8'h55, 1, 4'h7, 0, 8'h00);
    bus(1, 1, 1, 1, 16'h2002, 8'hEA, 0, 4'h3, 0, 8'h00);

    // LDA (zp),Y no page cross, chained straight into a second LDA (zp),Y
    bus(1, 1, 1, 1, 16'h2003, 8'hB1, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2004, 8'h20, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0020, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0021, 8'h50, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h5000, 8'hAA, 1, 4'h7, 0, 8'h00);
    bus(1, 1, 1, 1, 16'h2005, 8'hB1, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2006, 8'h30, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0030, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0031, 8'h60, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h6000, 8'h00, 1, 4'h7, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h6100, 8'h00, 1, 4'h7, 0, 8'h00);
    bus(1, 1, 1, 1, 16'h2007, 8'hEA, 0, 4'h3, 0, 8'h00);

    // RDY low for three read cycles in PTRH
    bus(1, 1, 1, 1, 16'h2008, 8'hB1, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2009, 8'h40, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0040, 8'h00, 0, 4'h3, 0, 8'h00);
    for (int i = 0; i < 3; i++) bus(1, 1, 0, 0, 16'h0041, 8'h70, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0041, 8'h70, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h7000, 8'h00, 1, 4'h7, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h7100, 8'h00, 1, 4'h7, 0, 8'h00);

    // LDA (zp,X) must never start the sequence
    bus(1, 1, 1, 1, 16'h200A, 8'hA1, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h200B, 8'h40, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0040, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0041, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0042, 8'h70, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h7000, 8'h00, 0, 4'h3, 0, 8'h00);

    // Matching opcode on a stalled sync cycle is ignored
    bus(1, 1, 0, 1, 16'h200C, 8'hB1, 0, 4'h3, 0, 8'h00);
    for (int i = 0; i < 5; i++) bus(1, 1, 1, 0, 16'h200D, 8'h00, 0, 4'h3, 0, 8'h00);

    // Write $0001 during EA1: current cycle keeps the old indirect bank
    bus(1, 1, 1, 1, 16'h2010, 8'h91, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2011, 8'h12, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0012, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0013, 8'h80, 0, 4'h3, 0, 8'h00);
    bus(1, 0, 1, 0, 16'h0001, 8'h09, 1, 4'h7, 0, 8'h00); in_e = 4'h9;
    bus(1, 0, 1, 0, 16'h8010, 8'h55, 1, 4'h9, 0, 8'h00);
    bus(1, 1, 1, 1, 16'h2012, 8'hEA, 0, 4'h3, 0, 8'h00);

    // Reset asserted in EA1 acts before the next clock edge
    bus(1, 1, 1, 1, 16'h2013, 8'h91, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2014, 8'h14, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0014, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0015, 8'h80, 0, 4'h3, 0, 8'h00);
    ex_e = 4'hF; in_e = 4'hF;
    bus(0, 1, 1, 0, 16'h8000, 8'h00, 0, 4'hF, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h1000, 8'h00, 0, 4'hF, 0, 8'h00);
    bus(1, 0, 1, 0, 16'h0000, 8'h03, 0, 4'hF, 0, 8'h00); ex_e = 4'h3;
    bus(1, 0, 1, 0, 16'h0001, 8'h07, 0, 4'h3, 0, 8'h00); in_e = 4'h7;

    // RDY low on the EA2 write cycle
    bus(1, 1, 1, 1, 16'h2020, 8'h91, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2021, 8'h16, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0016, 8'h00, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h0017, 8'h90, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h9000, 8'h00, 1, 4'h7, 0, 8'h00);
    bus(1, 0, 0, 0, 16'h9010, 8'h55, 1, 4'h7, 0, 8'h00);
`ifdef CMOS_RDY_EN
    bus(1, 0, 1, 0, 16'h9010, 8'h55, 1, 4'h7, 0, 8'h00);
`else
    bus(1, 0, 1, 0, 16'h9010, 8'h55, 0, 4'h3, 0, 8'h00);
`endif
    bus(1, 1, 1, 1, 16'h2022, 8'hEA, 0, 4'h3, 0, 8'h00);
    bus(1, 1, 1, 0, 16'h2023, 8'h00, 0, 4'h3, 0, 8'h00);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
